// File: rtl/audio_sched_pkg.sv
// Shared types and codes for the audio source scheduler.
// State machine encoding, source selectors and spi_config mode codes.
package audio_sched_pkg;

    typedef enum logic [1:0] {
        MUTE     = 2'b00,
        FADE_IN  = 2'b01,
        RUN      = 2'b10,
        FADE_OUT = 2'b11
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_I2S  = 2'b01;
    localparam logic [1:0] SRC_USB  = 2'b10;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_I2S  = 2'b01;
    localparam logic [1:0] MODE_USB  = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

endpackage

// File: rtl/src_watchdog.sv
// Liveness watchdog for one audio source: counts idle cycles since the last
// strobe and saturates at TIMEOUT, at which point the source is dead.
module src_watchdog #(
    parameter int TO_W    = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic dv,
    output logic alive
);

    localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0] cnt_r;
    logic [TO_W-1:0] cnt_nx_s;
    logic            alive_r;

    // Next idle count: a strobe always wins, even on the cycle the limit is hit.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (dv) begin
            cnt_nx_s = {TO_W{1'b0}};
        end else if (cnt_r < LIMIT) begin
            cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Idle counter and registered liveness flag; reset starts the source dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= LIMIT;
            alive_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nx_s;
            alive_r <= (cnt_nx_s < LIMIT);
        end
    end

    assign alive = alive_r;

endmodule

// File: rtl/audio_src_sched.sv
// Chooses between the I2S and USB audio paths for fm_modulator, ramping the
// gain down to silence and back up on every source change.
module audio_src_sched
    import audio_sched_pkg::*;
#(
    parameter int A       = 8,
    parameter int G       = 4,
    parameter int TO_W    = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         usb_connected,
    input  logic [A-1:0] i2s_data,
    input  logic         i2s_dv,
    input  logic [A-1:0] usb_data,
    input  logic         usb_dv,
    output logic [A-1:0] audio_out,
    output logic         audio_valid,
    output logic [1:0]   src_cur,
    output logic         fading,
    output logic         dropout
);

    localparam logic [G:0] GAIN_ZERO = {(G+1){1'b0}};
    localparam logic [G:0] GAIN_ONE  = {{G{1'b0}}, 1'b1};
    localparam logic [G:0] GAIN_FULL = {1'b1, {G{1'b0}}};

    logic           i2s_alive_s;
    logic           usb_alive_s;
    logic [1:0]     desired_s;
    logic           cur_alive_s;
    logic           acc_s;
    logic [A-1:0]   sample_s;
    logic           enter_mute_s;
    logic [A+G-1:0] prod_s;
    logic [A-1:0]   scaled_s;

    state_e         state_r;
    logic [1:0]     src_r;
    logic [G:0]     gain_r;
    logic [A-1:0]   audio_out_r;
    logic           audio_valid_r;
    logic           fading_r;
    logic           dropout_r;

    src_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_i2s_wd (
        .clk   (clk),
        .rst   (rst),
        .dv    (i2s_dv),
        .alive (i2s_alive_s)
    );

    src_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_usb_wd (
        .clk   (clk),
        .rst   (rst),
        .dv    (usb_dv),
        .alive (usb_alive_s)
    );

    // Source the configuration wants right now, given which sources are alive.
    always_comb begin
        desired_s = SRC_NONE;
        case (mode)
            MODE_I2S: desired_s = i2s_alive_s ? SRC_I2S : SRC_NONE;
            MODE_USB: desired_s = (usb_alive_s && usb_connected) ? SRC_USB : SRC_NONE;
            MODE_AUTO: begin
                if (usb_alive_s && usb_connected) begin
                    desired_s = SRC_USB;
                end else if (i2s_alive_s) begin
                    desired_s = SRC_I2S;
                end else begin
                    desired_s = SRC_NONE;
                end
            end
            default: desired_s = SRC_NONE;
        endcase
    end

    // Strobe, sample and liveness of the source currently on air.
    always_comb begin
        cur_alive_s = 1'b0;
        acc_s       = 1'b0;
        sample_s    = i2s_data;
        case (src_r)
            SRC_I2S: begin
                cur_alive_s = i2s_alive_s;
                acc_s       = i2s_dv;
                sample_s    = i2s_data;
            end
            SRC_USB: begin
                cur_alive_s = usb_alive_s;
                acc_s       = usb_dv;
                sample_s    = usb_data;
            end
            default: begin
                cur_alive_s = 1'b0;
                acc_s       = 1'b0;
                sample_s    = i2s_data;
            end
        endcase
    end

    // Sign-extended sample times zero-extended gain; the top product bit never survives truncation.
    assign prod_s   = {{G{sample_s[A-1]}}, sample_s} * {{(A-1){1'b0}}, gain_r};
    assign scaled_s = A'(prod_s >> G);

    // Any active state falls to MUTE when its source dies or a fade-out bottoms out.
    always_comb begin
        enter_mute_s = 1'b0;
        if (state_r == MUTE) begin
            enter_mute_s = 1'b0;
        end else if (!cur_alive_s) begin
            enter_mute_s = 1'b1;
        end else if ((state_r == FADE_OUT) && (desired_s != src_r)) begin
            enter_mute_s = (gain_r == GAIN_ZERO) || (acc_s && (gain_r == GAIN_ONE));
        end else begin
            enter_mute_s = 1'b0;
        end
    end

    // Scheduler FSM with registered datapath and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= MUTE;
            src_r         <= SRC_NONE;
            gain_r        <= GAIN_ZERO;
            audio_out_r   <= {A{1'b0}};
            audio_valid_r <= 1'b0;
            fading_r      <= 1'b0;
            dropout_r     <= 1'b0;
        end else begin
            audio_valid_r <= 1'b0;
            if (acc_s) begin
                audio_out_r   <= scaled_s;
                audio_valid_r <= 1'b1;
            end
            if (enter_mute_s) begin
                state_r       <= MUTE;
                src_r         <= SRC_NONE;
                gain_r        <= GAIN_ZERO;
                audio_out_r   <= {A{1'b0}};
                audio_valid_r <= 1'b1;
                fading_r      <= 1'b0;
                if (state_r == RUN) begin
                    dropout_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    MUTE: begin
                        gain_r <= GAIN_ZERO;
                        src_r  <= desired_s;
                        if (desired_s != SRC_NONE) begin
                            state_r  <= FADE_IN;
                            fading_r <= 1'b1;
                        end
                    end
                    FADE_IN: begin
                        if (desired_s != src_r) begin
                            state_r <= FADE_OUT;
                        end else if (gain_r == GAIN_FULL) begin
                            state_r  <= RUN;
                            fading_r <= 1'b0;
                        end else if (acc_s) begin
                            gain_r <= gain_r + GAIN_ONE;
                            if ((gain_r + GAIN_ONE) == GAIN_FULL) begin
                                state_r  <= RUN;
                                fading_r <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        gain_r <= GAIN_FULL;
                        if (desired_s != src_r) begin
                            state_r  <= FADE_OUT;
                            fading_r <= 1'b1;
                        end
                    end
                    FADE_OUT: begin
                        if (desired_s == src_r) begin
                            state_r <= FADE_IN;
                        end else if (acc_s) begin
                            gain_r <= gain_r - GAIN_ONE;
                        end
                    end
                    default: begin
                        state_r     <= MUTE;
                        src_r       <= SRC_NONE;
                        gain_r      <= GAIN_ZERO;
                        audio_out_r <= {A{1'b0}};
                        fading_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign audio_out   = audio_out_r;
    assign audio_valid = audio_valid_r;
    assign src_cur     = src_r;
    assign fading      = fading_r;
    assign dropout     = dropout_r;

endmodule

// File: doc/audio_src_sched.md
Name: audio_src_sched

Overview:
- Clock-domain (clk) scheduler that decides which audio source feeds fm_modulator: the I2S receiver path or the USB audio path.
- Tracks liveness of each source with timeout counters and applies the mode requested by spi_config.
- On every source change it fades the old source out to silence and fades the new source in, so the carrier never sees a step.
- Sits between cdc_slow2fast_bus / usb_audio_top outputs and the fm_modulator audio input.

Parameters:
- A, 8, audio sample width (signed two's complement).
- G, 4, gain fraction bits; a fade lasts 2^G accepted samples.
- TO_W, 12, width of each liveness timeout counter.
- TIMEOUT, 4095, idle clk cycles after the last strobe before a source is declared dead (> one 48 kHz period at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mode  in  2  00 auto (USB preferred), 01 force I2S, 10 force USB, 11 mute
- usb_connected  in  1  USB enumerated flag
- i2s_data  in  A  I2S sample, already synchronised to clk
- i2s_dv  in  1  single-cycle strobe, i2s_data valid
- usb_data  in  A  USB sample (top A bits of the 16-bit sample)
- usb_dv  in  1  single-cycle strobe, usb_data valid
- audio_out  out  A  scaled sample to fm_modulator
- audio_valid  out  1  pulse, audio_out updated this cycle
- src_cur  out  2  00 none, 01 I2S, 10 USB
- fading  out  1  high in FADE_IN or FADE_OUT
- dropout  out  1  sticky; set when the current source dies while in RUN; cleared only by rst

Behaviour:
- Reset (async): state MUTE, src_cur=00, gain=0, both timeout counters=TIMEOUT (both dead), audio_out=0, audio_valid=0, fading=0, dropout=0.
- Liveness:
  - Per source, the counter loads 0 on its dv; otherwise it increments and saturates at TIMEOUT.
  - alive = counter < TIMEOUT.
  - A dv arriving in the same cycle the counter reaches TIMEOUT wins: the counter loads 0.
- Desired source (combinational):
  - mode 11 -> none.
  - mode 01 -> I2S if alive, else none.
  - mode 10 -> USB if alive and usb_connected, else none.
  - mode 00 -> USB if alive and usb_connected; else I2S if alive; else none.
- Accepted strobe: the dv of src_cur only. Strobes from the other source are ignored for the datapath but still feed liveness. Simultaneous i2s_dv and usb_dv are legal.
- FSM:
  - MUTE: gain=0. If desired != none, load src_cur=desired and go to FADE_IN in the same cycle. If desired = none, src_cur=00.
  - FADE_IN:
    - Each accepted strobe increments gain by 1; at gain=2^G go to RUN.
    - If desired != src_cur, go to FADE_OUT.
    - If src_cur dies, set gain=0 and go to MUTE.
  - RUN: gain=2^G.
    - If desired != src_cur: if src_cur is alive go to FADE_OUT; if src_cur is dead, set dropout=1, gain=0, and go to MUTE.
  - FADE_OUT:
    - Each accepted strobe decrements gain by 1; at gain=0 go to MUTE.
    - If src_cur dies, set gain=0 and go to MUTE.
    - If desired becomes equal to src_cur again, go to FADE_IN without resetting gain.
- Datapath:
  - product = signed(sample) * unsigned (G+1)-bit gain, A+G+1 bits wide; audio_out = product >>> G, truncated to A bits.
  - Rounding is toward -inf. gain=2^G passes the sample through exactly.
  - The gain used is the value before the update caused by the same strobe.
- Latency: audio_out and audio_valid are registered one cycle after the accepted dv. audio_out holds between strobes.
- Entering MUTE forces audio_out=0 with one audio_valid pulse in that cycle.
- Mid-operation rst: immediate return to reset values, with no fade.
- fading = (state==FADE_IN) | (state==FADE_OUT).

Decomposition:
- Package audio_sched_pkg holds:
  - the state enum (MUTE, FADE_IN, RUN, FADE_OUT);
  - src codes (SRC_NONE=2'b00, SRC_I2S=2'b01, SRC_USB=2'b10);
  - mode codes (MODE_AUTO, MODE_I2S, MODE_USB, MODE_MUTE).
- One sub-module, src_watchdog (parameters TO_W and TIMEOUT; ports clk, rst, dv, alive), instantiated twice.

Test Plan:
- mode=01, i2s_dv every 1000 cycles with i2s_data=8'h40 -> MUTE->FADE_IN; audio_out ramps 4,8,...,0x40; RUN after 16 strobes; fading falls.
- In RUN on I2S (mode 00), usb_connected=1 and usb_dv starts -> FADE_OUT over 16 I2S strobes to 0, MUTE, src_cur=10, FADE_IN on USB strobes.
- RUN on I2S, i2s_dv stops -> TIMEOUT+1 cycles later: MUTE, audio_out=0, dropout=1; dropout stays 1 after I2S resumes.
- Negative sample 8'h81 at gain=1 -> audio_out=8'hF8 (rounding toward -inf); at gain=16 -> 8'h81.
- FADE_OUT at gain=9, mode switched back to the current source -> FADE_IN from gain 9, no drop to 0.
- rst asserted mid-FADE_IN -> all outputs 0 in the same cycle, no audio_valid until the next fade-in.
